dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle, word-addressed data memory answering MEM-stage loads/stores with a busy stall.
// Define DMEM_BOUNDS_CHECK_EN to add out-of-range detection and the err output pulse.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
`ifdef DMEM_BOUNDS_CHECK_EN
  output logic        err,
`endif
  output logic        busy
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int IDX_HI = IDX_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             is_wr_q, is_wr_d;
  logic             is_rd_q, is_rd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             oor_q, oor_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rdata_valid_q, rdata_valid_d;
  logic             enter_done;

  logic [IDX_W-1:0] req_idx;
  logic             req_oor;
  logic             unused_addr_bits;

  logic [31:0]      mem [DEPTH_WORDS];

  assign req_idx          = addr[IDX_HI:2];
  assign unused_addr_bits = ^{addr[31:IDX_HI+1], addr[1:0]};

`ifdef DMEM_BOUNDS_CHECK_EN
  logic err_q, err_d;

  assign req_oor = |addr[31:IDX_HI+1];
`else
  assign req_oor = 1'b0;
`endif

  // Request latch and wait-state sequencing; inputs are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    is_rd_d = is_rd_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    oor_d   = oor_q;
    busy    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = mem_read | mem_write;
        if (mem_read | mem_write) begin
          is_wr_d = mem_write;
          is_rd_d = mem_read & ~mem_write;
          idx_d   = req_idx;
          wdata_d = wdata;
          oor_d   = req_oor;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: begin
        busy  = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The _d copies hold the request even on the IDLE->DONE path, so loads read with them.
  always_comb begin
    enter_done    = (state_d == ST_DONE) && (state_q != ST_DONE);
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    if (enter_done && is_rd_d) begin
      rdata_valid_d = 1'b1;
      rdata_d       = oor_d ? 32'h0 : mem[idx_d];
    end
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  always_comb begin
    err_d = enter_done && oor_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      is_wr_q       <= 1'b0;
      is_rd_q       <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= 32'h0;
      oor_q         <= 1'b0;
      rdata_q       <= 32'h0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_wr_q       <= is_wr_d;
      is_rd_q       <= is_rd_d;
      idx_q         <= idx_d;
      wdata_q       <= wdata_d;
      oor_q         <= oor_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  // Storage is deliberately not reset; a reset during DONE drops the pending write.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == ST_DONE) && is_wr_q && !oor_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a load-data scoreboard and a reference memory model.
// Follows DMEM_BOUNDS_CHECK_EN so the same bench covers both builds.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WAITS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        busy;
  logic        err;

  int checks = 0;
  int passes = 0;
  int fails = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] sb_q [$];
  logic [31:0] last_rd = 32'h0;
  logic [31:0] sb_exp;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
  assign err = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
`ifdef DMEM_BOUNDS_CHECK_EN
    .err        (err),
`endif
    .busy       (busy)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request from posedge+1 in IDLE, optionally changing addr/wdata mid-wait,
  // and returns at posedge+1 in the IDLE cycle after DONE.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input int change_at,
                                input logic [31:0] a2, input logic [31:0] d2);
    logic       is_rd;
    logic       oor;
    logic [7:0] idx;
    int         busy_cnt;
    is_rd = rd & ~wr;
    idx   = a[9:2];
    oor   = OOR_EN && (a[31:10] != 22'h0);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    if (is_rd) sb_q.push_back(oor ? 32'h0 : model[idx]);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      busy_cnt++;
      @(posedge clk);
      #1;
      if (busy_cnt == change_at) begin
        addr  = a2;
        wdata = d2;
      end
    end
    check_output("busy_cycles", busy_cnt, WAITS + 1);
    check_output("valid_in_done", {31'h0, rdata_valid}, {31'h0, is_rd});
    check_output("err_in_done", {31'h0, err}, {31'h0, oor});
    if (!is_rd) check_output("rdata_hold", rdata, last_rd);
    if (wr && !oor) model[idx] = d;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    check_output("valid_cleared", {31'h0, rdata_valid}, 32'h0);
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    apply_stimulus(rd, wr, a, d, -1, 32'h0, 32'h0);
  endtask

  // Every load completion pops the value the model predicted when the load was issued.
  always @(negedge clk) begin
    if (!reset && rdata_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_output("unexpected_valid", 32'h1, 32'h0);
      end else begin
        sb_exp = sb_q.pop_front();
        check_output("load_data", rdata, sb_exp);
        last_rd = sb_exp;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("idle_busy", {31'h0, busy}, 32'h0);
      check_output("idle_rdata", rdata, 32'h0);
      check_output("idle_valid", {31'h0, rdata_valid}, 32'h0);
    end
    @(posedge clk);
    #1;

    $display("[TB] store/load 0x10");
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h10, 32'h0);

    $display("[TB] inputs change during wait of store to 0x20");
    apply_stimulus(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1, 32'h60, 32'h11111111);
    access(1'b1, 1'b0, 32'h20, 32'h0);
    access(1'b1, 1'b0, 32'h60, 32'h0);

    $display("[TB] reset during wait of store to 0x40");
    mem_write = 1'b1;
    addr      = 32'h40;
    wdata     = 32'h12345678;
    @(negedge clk);
    check_output("busy_on_accept", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    last_rd = 32'h0;
    @(negedge clk);
    check_output("post_reset_busy", {31'h0, busy}, 32'h0);
    check_output("post_reset_rdata", rdata, 32'h0);
    check_output("post_reset_valid", {31'h0, rdata_valid}, 32'h0);
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'h40, 32'h0);

    $display("[TB] read and write together at 0x04");
    access(1'b1, 1'b1, 32'h04, 32'hA5A5A5A5);
    access(1'b1, 1'b0, 32'h04, 32'h0);

    $display("[TB] address beyond the array at 0x400");
    access(1'b0, 1'b1, 32'h400, 32'h1);
    access(1'b1, 1'b0, 32'h0, 32'h0);
    access(1'b1, 1'b0, 32'h400, 32'h0);

    $display("[TB] mixed accesses");
    for (int i = 0; i < 12; i++) begin
      logic        rd;
      logic [31:0] a;
      rd = 1'($urandom_range(0, 1));
      a  = {22'h0, 8'($urandom_range(0, 31)), 2'b00};
      access(rd, ~rd, a, $urandom);
    end

    @(negedge clk);
    check_output("scoreboard_empty", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
